// File: rtl/writeback_unit.sv
// Register-file writeback stage: merges ALU results and in-order load returns into one write per cycle.
// Optional macro WB_BYPASS_EN forwards the in-flight write to decode operands; without it, decode stalls one cycle instead.
module writeback_unit #(
    parameter int DATA_W    = 16,
    parameter int ADDR_W    = 3,
    parameter int LDQ_DEPTH = 2
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 alu_valid,
    input  logic [ADDR_W-1:0]    alu_rd,
    input  logic [DATA_W-1:0]    alu_dat,
    input  logic                 ld_issue,
    input  logic [ADDR_W-1:0]    ld_issue_rd,
    output logic                 ld_issue_ready,
    input  logic                 ld_valid,
    input  logic [DATA_W-1:0]    ld_dat,
    output logic                 ld_ready,
    output logic [ADDR_W-1:0]    tgt,
    output logic [DATA_W-1:0]    tgt_dat,
    input  logic [ADDR_W-1:0]    src1,
    input  logic [ADDR_W-1:0]    src2,
    input  logic [DATA_W-1:0]    rf_src1_dat,
    input  logic [DATA_W-1:0]    rf_src2_dat,
    output logic [DATA_W-1:0]    src1_dat,
    output logic [DATA_W-1:0]    src2_dat,
    output logic                 src1_busy,
    output logic                 src2_busy,
    output logic [2**ADDR_W-1:0] busy
);

    localparam int PTR_W = $clog2(LDQ_DEPTH);
    localparam int CNT_W = PTR_W + 1;
    localparam logic [CNT_W-1:0] FULL = CNT_W'(LDQ_DEPTH);

    logic [ADDR_W-1:0]   ldq [LDQ_DEPTH];
    logic [PTR_W-1:0]    head;
    logic [PTR_W-1:0]    tail;
    logic [CNT_W-1:0]    count;
    logic [ADDR_W-1:0]   head_rd;
    logic                push;
    logic                pop;
    logic [2**ADDR_W-1:0] busy_next;

    assign head_rd        = ldq[head];
    assign ld_ready       = (count != '0) && !alu_valid;
    assign pop            = ld_valid && ld_ready;
    assign ld_issue_ready = (count < FULL) && ((ld_issue_rd == '0) || !busy[ld_issue_rd]);
    assign push           = ld_issue && ld_issue_ready;

    // A pushed rd can never equal a busy head rd, so the clear and set never collide.
    always_comb begin
        busy_next = busy;
        if (pop)
            busy_next[head_rd] = 1'b0;
        if (push && (ld_issue_rd != '0))
            busy_next[ld_issue_rd] = 1'b1;
        busy_next[0] = 1'b0;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            head  <= '0;
            tail  <= '0;
            count <= '0;
            busy  <= '0;
        end else begin
            busy <= busy_next;
            if (push)
                tail <= tail + 1'b1;
            if (pop)
                head <= head + 1'b1;
            if (push && !pop)
                count <= count + 1'b1;
            else if (pop && !push)
                count <= count - 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (push)
            ldq[tail] <= ld_issue_rd;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            tgt     <= '0;
            tgt_dat <= '0;
        end else if (alu_valid) begin
            tgt     <= alu_rd;
            tgt_dat <= alu_dat;
        end else if (pop) begin
            tgt     <= head_rd;
            tgt_dat <= ld_dat;
        end else begin
            tgt     <= '0;
        end
    end

`ifdef WB_BYPASS_EN
    always_comb begin
        src1_dat  = ((tgt != '0) && (tgt == src1)) ? tgt_dat : rf_src1_dat;
        src2_dat  = ((tgt != '0) && (tgt == src2)) ? tgt_dat : rf_src2_dat;
        src1_busy = (src1 != '0) && busy[src1];
        src2_busy = (src2 != '0) && busy[src2];
    end
`else
    always_comb begin
        src1_dat  = rf_src1_dat;
        src2_dat  = rf_src2_dat;
        src1_busy = ((src1 != '0) && busy[src1]) || ((tgt != '0) && (tgt == src1));
        src2_busy = ((src2 != '0) && busy[src2]) || ((tgt != '0) && (tgt == src2));
    end
`endif

    // Decode must never let an ALU result target a register still awaiting its load.
    assert property (@(posedge clk) disable iff (rst)
        !(alu_valid && (alu_rd != '0) && busy[alu_rd]));

endmodule

// File: tb/tb_writeback_unit.sv
// Directed bench for writeback_unit: write selection, load queue, scoreboard and operand bypass/stall.
module tb_writeback_unit;

    logic        clk = 1'b0;
    logic        rst;
    logic        alu_valid;
    logic [2:0]  alu_rd;
    logic [15:0] alu_dat;
    logic        ld_issue;
    logic [2:0]  ld_issue_rd;
    logic        ld_issue_ready;
    logic        ld_valid;
    logic [15:0] ld_dat;
    logic        ld_ready;
    logic [2:0]  tgt;
    logic [15:0] tgt_dat;
    logic [2:0]  src1, src2;
    logic [15:0] rf_src1_dat, rf_src2_dat;
    logic [15:0] src1_dat, src2_dat;
    logic        src1_busy, src2_busy;
    logic [7:0]  busy;

    int passed = 0;
    int total  = 0;

    writeback_unit #(.DATA_W(16), .ADDR_W(3), .LDQ_DEPTH(2)) dut (
        .clk(clk), .rst(rst),
        .alu_valid(alu_valid), .alu_rd(alu_rd), .alu_dat(alu_dat),
        .ld_issue(ld_issue), .ld_issue_rd(ld_issue_rd), .ld_issue_ready(ld_issue_ready),
        .ld_valid(ld_valid), .ld_dat(ld_dat), .ld_ready(ld_ready),
        .tgt(tgt), .tgt_dat(tgt_dat),
        .src1(src1), .src2(src2),
        .rf_src1_dat(rf_src1_dat), .rf_src2_dat(rf_src2_dat),
        .src1_dat(src1_dat), .src2_dat(src2_dat),
        .src1_busy(src1_busy), .src2_busy(src2_busy),
        .busy(busy)
    );

    always #5 clk = ~clk;

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset;
        rst = 1'b1; alu_valid = 1'b1; alu_rd = 3'd3; alu_dat = 16'hDEAD;
        ld_issue = 1'b0; ld_issue_rd = 3'd0; ld_valid = 1'b1; ld_dat = 16'hBEEF;
        src1 = 3'd0; src2 = 3'd0; rf_src1_dat = 16'h0; rf_src2_dat = 16'h0;
        tick; tick;
        rst = 1'b0; alu_valid = 1'b0;
        #1;
        total++; if (tgt !== 3'd0) $display("FAIL reset_tgt: got %0d expected 0", tgt); else passed++;
        total++; if (tgt_dat !== 16'h0) $display("FAIL reset_tgt_dat: got %h expected 0000", tgt_dat); else passed++;
        total++; if (busy !== 8'h00) $display("FAIL reset_busy: got %h expected 00", busy); else passed++;
        total++; if (ld_ready !== 1'b0) $display("FAIL reset_ld_ready: got %b expected 0", ld_ready); else passed++;
        total++; if (ld_issue_ready !== 1'b1) $display("FAIL reset_issue_ready: got %b expected 1", ld_issue_ready); else passed++;
        tick;
        total++; if (tgt !== 3'd0) $display("FAIL empty_ld_ignored: got tgt %0d expected 0", tgt); else passed++;
        ld_valid = 1'b0;
    endtask

    task automatic test_alu_write;
        alu_valid = 1'b1; alu_rd = 3'd3; alu_dat = 16'h1234;
        rf_src1_dat = 16'h0BAD; rf_src2_dat = 16'h0C0D;
        tick;
        alu_valid = 1'b0; src1 = 3'd3; src2 = 3'd2;
        #1;
        total++; if (tgt !== 3'd3) $display("FAIL alu_tgt: got %0d expected 3", tgt); else passed++;
        total++; if (tgt_dat !== 16'h1234) $display("FAIL alu_tgt_dat: got %h expected 1234", tgt_dat); else passed++;
`ifdef WB_BYPASS_EN
        total++; if (src1_dat !== 16'h1234) $display("FAIL alu_bypass_dat: got %h expected 1234", src1_dat); else passed++;
        total++; if (src1_busy !== 1'b0) $display("FAIL alu_bypass_busy: got %b expected 0", src1_busy); else passed++;
`else
        total++; if (src1_dat !== 16'h0BAD) $display("FAIL alu_nobypass_dat: got %h expected 0bad", src1_dat); else passed++;
        total++; if (src1_busy !== 1'b1) $display("FAIL alu_nobypass_busy: got %b expected 1", src1_busy); else passed++;
`endif
        total++; if (src2_dat !== 16'h0C0D) $display("FAIL alu_src2_nomatch: got %h expected 0c0d", src2_dat); else passed++;
        total++; if (src2_busy !== 1'b0) $display("FAIL alu_src2_busy: got %b expected 0", src2_busy); else passed++;
        tick;
        total++; if (tgt !== 3'd0) $display("FAIL alu_idle_tgt: got %0d expected 0", tgt); else passed++;
        total++; if (tgt_dat !== 16'h1234) $display("FAIL alu_idle_dat_held: got %h expected 1234", tgt_dat); else passed++;
        total++; if (src1_dat !== 16'h0BAD) $display("FAIL alu_after_rf: got %h expected 0bad", src1_dat); else passed++;
        total++; if (src1_busy !== 1'b0) $display("FAIL alu_after_busy: got %b expected 0", src1_busy); else passed++;
        src1 = 3'd0; src2 = 3'd0;
    endtask

    task automatic test_load_flow;
        ld_issue = 1'b1; ld_issue_rd = 3'd5;
        #1;
        total++; if (ld_issue_ready !== 1'b1) $display("FAIL ld_issue1_ready: got %b expected 1", ld_issue_ready); else passed++;
        tick;
        ld_issue_rd = 3'd6;
        #1;
        total++; if (ld_issue_ready !== 1'b1) $display("FAIL ld_issue2_ready: got %b expected 1", ld_issue_ready); else passed++;
        tick;
        ld_issue_rd = 3'd2;
        #1;
        total++; if (busy !== 8'h60) $display("FAIL ld_busy_60: got %h expected 60", busy); else passed++;
        total++; if (ld_issue_ready !== 1'b0) $display("FAIL ld_full_ready: got %b expected 0", ld_issue_ready); else passed++;
        src1 = 3'd5;
        #1;
        total++; if (src1_busy !== 1'b1) $display("FAIL ld_src1_busy: got %b expected 1", src1_busy); else passed++;
        tick;
        ld_issue = 1'b0;
        total++; if (busy !== 8'h60) $display("FAIL ld_full_no_push: got %h expected 60", busy); else passed++;
        ld_valid = 1'b1; ld_dat = 16'hAAAA;
        #1;
        total++; if (ld_ready !== 1'b1) $display("FAIL ld_ready_first: got %b expected 1", ld_ready); else passed++;
        tick;
        ld_dat = 16'hBBBB;
        total++; if (tgt !== 3'd5) $display("FAIL ld_ret1_tgt: got %0d expected 5", tgt); else passed++;
        total++; if (tgt_dat !== 16'hAAAA) $display("FAIL ld_ret1_dat: got %h expected aaaa", tgt_dat); else passed++;
        total++; if (busy !== 8'h40) $display("FAIL ld_ret1_busy: got %h expected 40", busy); else passed++;
        tick;
        ld_valid = 1'b0; src1 = 3'd6;
        #1;
        total++; if (tgt !== 3'd6) $display("FAIL ld_ret2_tgt: got %0d expected 6", tgt); else passed++;
        total++; if (tgt_dat !== 16'hBBBB) $display("FAIL ld_ret2_dat: got %h expected bbbb", tgt_dat); else passed++;
        total++; if (busy !== 8'h00) $display("FAIL ld_ret2_busy: got %h expected 00", busy); else passed++;
        total++; if (ld_ready !== 1'b0) $display("FAIL ld_drained_ready: got %b expected 0", ld_ready); else passed++;
`ifdef WB_BYPASS_EN
        total++; if (src1_dat !== 16'hBBBB) $display("FAIL ld_bypass_dat: got %h expected bbbb", src1_dat); else passed++;
`else
        total++; if (src1_busy !== 1'b1) $display("FAIL ld_nobypass_busy: got %b expected 1", src1_busy); else passed++;
`endif
        tick;
        src1 = 3'd0;
    endtask

    task automatic test_conflict;
        ld_issue = 1'b1; ld_issue_rd = 3'd5;
        tick;
        ld_issue = 1'b0;
        ld_valid = 1'b1; ld_dat = 16'hCCCC;
        alu_valid = 1'b1; alu_rd = 3'd2; alu_dat = 16'h0222;
        #1;
        total++; if (ld_ready !== 1'b0) $display("FAIL cf_ld_ready_blocked: got %b expected 0", ld_ready); else passed++;
        tick;
        alu_valid = 1'b0;
        #1;
        total++; if (tgt !== 3'd2) $display("FAIL cf_alu_tgt: got %0d expected 2", tgt); else passed++;
        total++; if (tgt_dat !== 16'h0222) $display("FAIL cf_alu_dat: got %h expected 0222", tgt_dat); else passed++;
        total++; if (busy !== 8'h20) $display("FAIL cf_busy_held: got %h expected 20", busy); else passed++;
        total++; if (ld_ready !== 1'b1) $display("FAIL cf_ld_ready: got %b expected 1", ld_ready); else passed++;
        tick;
        ld_valid = 1'b0;
        total++; if (tgt !== 3'd5) $display("FAIL cf_ld_tgt: got %0d expected 5", tgt); else passed++;
        total++; if (tgt_dat !== 16'hCCCC) $display("FAIL cf_ld_dat: got %h expected cccc", tgt_dat); else passed++;
        total++; if (busy !== 8'h00) $display("FAIL cf_busy_clear: got %h expected 00", busy); else passed++;
    endtask

    task automatic test_issue_busy;
        ld_issue = 1'b1; ld_issue_rd = 3'd4;
        tick;
        #1;
        total++; if (ld_issue_ready !== 1'b0) $display("FAIL ib_busy_ready: got %b expected 0", ld_issue_ready); else passed++;
        tick;
        ld_valid = 1'b1; ld_dat = 16'h4444;
        #1;
        total++; if (ld_issue_ready !== 1'b0) $display("FAIL ib_same_cycle_pop: got %b expected 0", ld_issue_ready); else passed++;
        total++; if (ld_ready !== 1'b1) $display("FAIL ib_ld_ready: got %b expected 1", ld_ready); else passed++;
        tick;
        ld_valid = 1'b0;
        #1;
        total++; if (tgt !== 3'd4) $display("FAIL ib_ret_tgt: got %0d expected 4", tgt); else passed++;
        total++; if (busy !== 8'h00) $display("FAIL ib_ret_busy: got %h expected 00", busy); else passed++;
        total++; if (ld_issue_ready !== 1'b1) $display("FAIL ib_next_ready: got %b expected 1", ld_issue_ready); else passed++;
        tick;
        ld_issue = 1'b0;
        total++; if (busy !== 8'h10) $display("FAIL ib_reissue_busy: got %h expected 10", busy); else passed++;
        ld_valid = 1'b1; ld_dat = 16'h5555;
        tick;
        ld_valid = 1'b0;
        total++; if (tgt_dat !== 16'h5555) $display("FAIL ib_drain_dat: got %h expected 5555", tgt_dat); else passed++;
        total++; if (busy !== 8'h00) $display("FAIL ib_drain_busy: got %h expected 00", busy); else passed++;
    endtask

    task automatic test_zero_reg;
        ld_issue = 1'b1; ld_issue_rd = 3'd0;
        #1;
        total++; if (ld_issue_ready !== 1'b1) $display("FAIL z_issue_ready: got %b expected 1", ld_issue_ready); else passed++;
        tick;
        ld_issue = 1'b0;
        #1;
        total++; if (busy !== 8'h00) $display("FAIL z_busy: got %h expected 00", busy); else passed++;
        total++; if (ld_ready !== 1'b1) $display("FAIL z_ld_ready: got %b expected 1", ld_ready); else passed++;
        ld_valid = 1'b1; ld_dat = 16'hFFFF;
        tick;
        ld_valid = 1'b0; src1 = 3'd0; rf_src1_dat = 16'h0000;
        #1;
        total++; if (tgt !== 3'd0) $display("FAIL z_tgt: got %0d expected 0", tgt); else passed++;
        total++; if (src1_dat !== 16'h0000) $display("FAIL z_src1_dat: got %h expected 0000", src1_dat); else passed++;
        total++; if (src1_busy !== 1'b0) $display("FAIL z_src1_busy: got %b expected 0", src1_busy); else passed++;
        total++; if (ld_ready !== 1'b0) $display("FAIL z_queue_empty: got %b expected 0", ld_ready); else passed++;
    endtask

    task automatic test_back_to_back;
        alu_valid = 1'b1; alu_rd = 3'd1; alu_dat = 16'h0101;
        tick;
        alu_rd = 3'd7; alu_dat = 16'h0707;
        total++; if (tgt !== 3'd1 || tgt_dat !== 16'h0101) $display("FAIL b2b_alu1: got %0d/%h expected 1/0101", tgt, tgt_dat); else passed++;
        tick;
        alu_valid = 1'b0;
        total++; if (tgt !== 3'd7 || tgt_dat !== 16'h0707) $display("FAIL b2b_alu2: got %0d/%h expected 7/0707", tgt, tgt_dat); else passed++;
        ld_issue = 1'b1; ld_issue_rd = 3'd5;
        tick;
        ld_issue_rd = 3'd6; ld_valid = 1'b1; ld_dat = 16'h1111;
        #1;
        total++; if (ld_issue_ready !== 1'b1) $display("FAIL b2b_pushpop_issue: got %b expected 1", ld_issue_ready); else passed++;
        tick;
        ld_issue = 1'b0; ld_dat = 16'h2222;
        total++; if (tgt !== 3'd5 || tgt_dat !== 16'h1111) $display("FAIL b2b_pop1: got %0d/%h expected 5/1111", tgt, tgt_dat); else passed++;
        total++; if (busy !== 8'h40) $display("FAIL b2b_pushpop_busy: got %h expected 40", busy); else passed++;
        tick;
        ld_valid = 1'b0;
        total++; if (tgt !== 3'd6 || tgt_dat !== 16'h2222) $display("FAIL b2b_pop2: got %0d/%h expected 6/2222", tgt, tgt_dat); else passed++;
        total++; if (busy !== 8'h00) $display("FAIL b2b_final_busy: got %h expected 00", busy); else passed++;
        #1;
        total++; if (ld_ready !== 1'b0) $display("FAIL b2b_empty: got %b expected 0", ld_ready); else passed++;
    endtask

    initial begin
        test_reset;
        test_alu_write;
        test_load_flow;
        test_conflict;
        test_issue_busy;
        test_zero_reg;
        test_back_to_back;
        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule

// File: doc/writeback_unit.md
Name: writeback_unit

Overview:
- Producer side of the 8 x 16-bit register file write/read interface.
- Accepts single-cycle ALU results and in-order load returns, then drives one registered write per cycle onto the file's tgt/tgt_dat.
- Tracks destinations of outstanding loads (scoreboard busy bits) and bypasses the in-flight write onto the decode-stage operand buses.

Parameters:
- DATA_W, 16, register data width
- ADDR_W, 3, register index width (2**ADDR_W registers; index 0 is hardwired zero)
- LDQ_DEPTH, 2, maximum outstanding loads (power of two, >=2)

Ports:
- clk  in  1  clock; all state updates on rising edge
- rst  in  1  synchronous, active-high reset
- alu_valid  in  1  ALU result present this cycle; cannot be stalled
- alu_rd  in  ADDR_W  ALU destination
- alu_dat  in  DATA_W  ALU result
- ld_issue  in  1  load issued; reserve destination
- ld_issue_rd  in  ADDR_W  load destination
- ld_issue_ready  out  1  issue accepted when ld_issue & ld_issue_ready
- ld_valid  in  1  load data returning (in issue order)
- ld_dat  in  DATA_W  load data
- ld_ready  out  1  load return accepted when ld_valid & ld_ready
- tgt  out  ADDR_W  register file write index (0 = no write)
- tgt_dat  out  DATA_W  register file write data
- src1, src2  in  ADDR_W  decode operand indices (same as sent to register file)
- rf_src1_dat, rf_src2_dat  in  DATA_W  register file combinational read data
- src1_dat, src2_dat  out  DATA_W  operand data after bypass
- src1_busy, src2_busy  out  1  operand hazard; decode must stall
- busy  out  2**ADDR_W  scoreboard; bit i = register i awaits a load

Behaviour:
- Reset (rst=1 at edge): tgt=0, tgt_dat=0, load queue empty, busy=0. ld_ready=0 while queue empty.
- Register file writes every cycle, so idle cycles drive tgt=0. Index 0 writes are harmless.
- Write selection each cycle, registered:
  - alu_valid=1 -> next tgt=alu_rd, tgt_dat=alu_dat.
  - else ld_valid & ld_ready -> next tgt=queue head rd, tgt_dat=ld_dat, pop queue.
  - else next tgt=0, tgt_dat unchanged.
- Latency: result accepted in cycle N -> on tgt in N+1 -> readable from file in N+2.
- ld_ready = queue not empty AND NOT alu_valid. ALU has strict priority; the load source holds ld_dat until accepted.
- ld_valid while queue empty: ignored, no write, no state change.
- ld_issue_ready = (count < LDQ_DEPTH) AND (ld_issue_rd==0 OR NOT busy[ld_issue_rd]).
  - Does not depend on a same-cycle pop.
  - Accepted issue pushes rd; sets busy[rd] if rd!=0.
- Pop clears busy[head rd]. Same-cycle push and pop both apply; count is unchanged.
- busy[0] is always 0. A load to rd 0 occupies a queue slot; its return produces tgt=0.
- alu_valid with alu_rd busy is a protocol violation. Decode prevents it via srcN_busy/busy. Behaviour is undefined; flag with an assertion.
- srcN_busy = (srcN!=0) AND busy[srcN].
- Bypass: srcN_dat = tgt_dat when (tgt!=0 AND tgt==srcN), else rf_srcN_dat.
  - srcN==0 always yields rf data (zero).
- Queue pointers wrap modulo LDQ_DEPTH; count is ADDR-independent, width log2(LDQ_DEPTH)+1.

Optional Feature:
- Macro WB_BYPASS_EN.
- Defined: bypass as above.
- Undefined:
  - srcN_dat = rf_srcN_dat.
  - srcN_busy additionally asserts when tgt!=0 AND tgt==srcN, forcing a one-cycle stall on a read of the in-flight write.
- Scoreboard is identical in both builds.

Test Plan:
- Reset: hold rst 2 cycles with ld_valid=1, alu_valid=1 -> tgt=0, tgt_dat=0, busy=0, ld_ready=0, ld_issue_ready=1 on the following cycle.
- ALU write: alu_valid, rd=3, dat=0x1234 at cycle N -> tgt=3, tgt_dat=0x1234 at N+1, tgt=0 at N+2. src1=3 at N+1 -> src1_dat=0x1234 (bypass build) or src1_busy=1 (no-bypass build).
- Load flow:
  - Issue rd=5 then rd=6 -> busy=0x60; third issue rd=2 -> ld_issue_ready=0.
  - Return 0xAAAA, 0xBBBB -> tgt 5 then 6, busy clears bit-by-bit.
- Conflict: ld_valid with queue head rd=5 and alu_valid rd=2 same cycle -> ld_ready=0, tgt=2 next cycle. Load accepted the cycle after, tgt=5.
- Issue to busy register: rd=4 outstanding, ld_issue rd=4 -> ld_issue_ready=0. Same cycle as its return -> still 0; next cycle -> 1.
- Zero register: issue rd=0 -> busy unchanged. Return 0xFFFF -> tgt=0; src1=0 yields rf data 0, src1_busy=0.
